// File: rtl/rf_mrp_clr.sv
// rtl/rf_mrp_clr.sv - parametrised multi-read register file with hardware clear sequencer
// Optional write-first read bypass: define RF_BYPASS_EN.
module rf_mrp_clr #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [NUM_RD*WIDTH-1:0]       o_rd_data,
    input  logic [$clog2(DEPTH)-1:0]      i_wr_addr,
    input  logic [WIDTH-1:0]              i_wr_data,
    input  logic                          i_wr_en,
    output logic                          o_wr_ready,
    input  logic                          i_clr,
    output logic                          o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            busy;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic wr_addr_ok;
    logic wr_zero_hit;
    logic wr_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // i_clr during CLEAR is deliberately ignored so the sweep is never restarted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_CLEAR);
        o_busy     = busy;
        o_wr_ready = ~busy;
    end

    always_comb begin
        wr_addr_ok  = ({1'b0, i_wr_addr} < DEPTH_W);
        wr_zero_hit = (ZERO_REG != 0) && (i_wr_addr == '0);
        wr_accept   = !busy && i_wr_en && !i_clr && wr_addr_ok && !wr_zero_hit;
    end

    // The clear sweep and normal writes share the single storage write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = i_wr_addr;
        mem_wdata = i_wr_data;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             addr_ok;
        logic             zero_hit;
        logic             byp_hit;
        logic [WIDTH-1:0] data;

        assign addr = i_rd_addr[k*AW +: AW];

        always_comb begin
            addr_ok  = ({1'b0, addr} < DEPTH_W);
            zero_hit = (ZERO_REG != 0) && (addr == '0);
            byp_hit  = BYPASS && wr_accept && (addr == i_wr_addr);
            data     = '0;
            if (!busy && addr_ok && !zero_hit) begin
                data = byp_hit ? i_wr_data : mem_q[addr];
            end
        end

        assign o_rd_data[k*WIDTH +: WIDTH] = data;
    end

endmodule

// File: tb/tb_rf_mrp_clr.sv
// tb/tb_rf_mrp_clr.sv - scoreboard bench for rf_mrp_clr (default and small ZERO_REG=0 instance)
module tb_rf_mrp_clr;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [9:0]  i_rd_addr = '0;
    logic [63:0] o_rd_data;
    logic [4:0]  i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic        i_wr_en = 1'b0;
    logic        o_wr_ready;
    logic        i_clr = 1'b0;
    logic        o_busy;

    logic [2:0]  n_rd_addr = '0;
    logic [15:0] n_rd_data;
    logic [2:0]  n_wr_addr = '0;
    logic [15:0] n_wr_data = '0;
    logic        n_wr_en = 1'b0;
    logic        n_wr_ready;
    logic        n_clr = 1'b0;
    logic        n_busy;

    always #5 clk = ~clk;

    rf_mrp_clr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_wr_en   (i_wr_en),
        .o_wr_ready(o_wr_ready),
        .i_clr     (i_clr),
        .o_busy    (o_busy)
    );

    rf_mrp_clr #(.WIDTH(16), .DEPTH(5), .NUM_RD(1), .ZERO_REG(0)) dut_nz (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_addr (n_rd_addr),
        .o_rd_data (n_rd_data),
        .i_wr_addr (n_wr_addr),
        .i_wr_data (n_wr_data),
        .i_wr_en   (n_wr_en),
        .o_wr_ready(n_wr_ready),
        .i_clr     (n_clr),
        .o_busy    (n_busy)
    );

    // kind: 0 rd port0, 1 rd port1, 2 busy, 3 wr_ready, 4 nz rd, 5 nz busy
    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic ex(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        i_rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        i_wr_en   = en;
        i_wr_addr = a;
        i_wr_data = d;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = o_rd_data[31:0];
                1:       act = o_rd_data[63:32];
                2:       act = {31'd0, o_busy};
                3:       act = {31'd0, o_wr_ready};
                4:       act = {16'd0, n_rd_data};
                default: act = {31'd0, n_busy};
            endcase
            n_checks++;
            if (act !== e.val) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    initial begin
        int guard;
        repeat (2) step();
        ex(2, 1, "busy_in_reset");
        ex(3, 0, "wready_in_reset");
        ex(0, 0, "rd0_in_reset");
        ex(5, 1, "nz_busy_in_reset");
        step();

        // Release reset while holding a write that must be dropped during the sweep
        rst_n = 1'b1;
        rd(5, 9);
        wr(1'b1, 5'd9, 32'h55);
        for (int i = 0; i < 32; i++) begin
            ex(2, 1, "busy_after_reset");
            ex(3, 0, "wready_during_clear");
            ex(0, 0, "rd0_during_clear");
            ex(1, 0, "rd1_during_clear");
            step();
        end
        wr(1'b0, 5'd0, 32'h0);
        ex(2, 0, "busy_end_of_clear");
        ex(3, 1, "wready_idle");
        step();

        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(a));
            ex(0, 0, "rd0_cleared");
            ex(1, 0, "rd1_cleared");
            step();
        end

        wr(1'b1, 5'd5, 32'hDEADBEEF);
        rd(5, 5);
        ex(0, BYP ? 32'hDEADBEEF : 32'h0, "rd0_addr5_same_cycle");
        step();
        wr(1'b0, 5'd0, 32'h0);
        ex(0, 32'hDEADBEEF, "rd0_addr5");
        ex(1, 32'hDEADBEEF, "rd1_addr5");
        step();

        wr(1'b1, 5'd0, 32'h12345678);
        rd(0, 0);
        ex(0, 0, "rd0_zero_reg_same_cycle");
        step();
        wr(1'b0, 5'd0, 32'h0);
        ex(0, 0, "rd0_zero_reg");
        ex(1, 0, "rd1_zero_reg");
        step();

        wr(1'b1, 5'd7, 32'hA5A5A5A5);
        rd(7, 3);
        ex(0, BYP ? 32'hA5A5A5A5 : 32'h0, "rdw_addr7_same_cycle");
        ex(1, 0, "rdw_other_port");
        step();
        wr(1'b0, 5'd0, 32'h0);
        ex(0, 32'hA5A5A5A5, "rdw_addr7_next");
        step();

        // Small instance: entry 0 ordinary, addresses 5..7 out of range
        n_wr_en = 1'b1; n_wr_addr = 3'd0; n_wr_data = 16'h1234; n_rd_addr = 3'd0;
        ex(4, BYP ? 32'h1234 : 32'h0, "nz_addr0_same_cycle");
        step();
        n_wr_addr = 3'd6; n_wr_data = 16'hBEEF; n_rd_addr = 3'd0;
        ex(4, 32'h1234, "nz_addr0");
        step();
        n_wr_addr = 3'd4; n_wr_data = 16'h4444; n_rd_addr = 3'd6;
        ex(4, 0, "nz_addr6_dropped");
        step();
        n_wr_en = 1'b0; n_rd_addr = 3'd4;
        ex(4, 32'h4444, "nz_addr4");
        ex(5, 0, "nz_idle");
        step();

        for (int a = 1; a < 32; a++) begin
            wr(1'b1, 5'(a), 32'(a));
            step();
        end
        wr(1'b0, 5'd0, 32'h0);
        rd(3, 31);
        ex(0, 32'd3, "fill_addr3");
        ex(1, 32'd31, "fill_addr31");
        step();

        // Clear wins over a simultaneous write
        i_clr = 1'b1;
        wr(1'b1, 5'd3, 32'hFFFF);
        ex(0, 32'd3, "clr_cycle_addr3_old");
        ex(1, 32'd31, "clr_cycle_addr31");
        ex(2, 0, "clr_cycle_busy");
        step();
        i_clr = 1'b0;
        wr(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            i_clr = (i == 10);
            ex(2, 1, "busy_after_clr");
            ex(0, 0, "rd0_busy_clr");
            ex(1, 0, "rd1_busy_clr");
            step();
        end
        i_clr = 1'b0;
        ex(2, 0, "busy_end_clr");
        ex(0, 0, "rd0_after_clr");
        ex(1, 0, "rd1_after_clr");
        step();

        // Reset in the middle of a clear sweep restarts it
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        ex(2, 1, "busy_mid_reset");
        ex(3, 0, "wready_mid_reset");
        step();
        rst_n = 1'b1;
        wr(1'b1, 5'd12, 32'h77);
        rd(12, 12);
        for (int i = 0; i < 32; i++) begin
            ex(2, 1, "busy_after_mid_reset");
            ex(3, 0, "wready_after_mid_reset");
            ex(0, 0, "rd0_after_mid_reset");
            step();
        end
        ex(2, 0, "busy_end_mid_reset");
        ex(3, 1, "wready_end_mid_reset");
        ex(0, BYP ? 32'h77 : 32'h0, "rd0_addr12_same_cycle");
        step();
        wr(1'b0, 5'd0, 32'h0);
        ex(0, 32'h77, "rd0_addr12_accepted");
        ex(1, 32'h77, "rd1_addr12_accepted");
        step();

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
